memory_stage: RTL

- Pipeline stage directly downstream of the execute stage. Consumes the 16-bit ALU result plus its control bundle and performs data-memory load/store and stack push/pop.
- Owns the stack pointer (SP) and the data memory array.
- Registers the write-back bundle (MEM/WB register) for the write-back stage.
- One operation per cycle; fixed 1-cycle latency from input to registered output.

---
 rtl/memory_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage. It performs data-memory load/store and
// stack push/pop, owns the stack pointer, and registers the MEM/WB bundle.
//
// Handshake: in_valid marks a live instruction. It takes effect at the edge
// only when stall=0 and flush=0. stall freezes every piece of state,
// including the outputs. flush (without stall) turns the cycle into a bubble.
// wb_valid marks the registered bundle as live for exactly one cycle per
// accepted instruction; the stage has no back-pressure output.
module memory_stage #(
  parameter int ADDR_W   = 10,
  parameter int SP_RESET = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              reg_write,
  input  logic [2:0]        rdst,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [2:0]        wb_rdst,
  output logic [15:0]       wb_data,
  output logic [ADDR_W-1:0] sp_out
);

  localparam int DEPTH = 2**ADDR_W;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] addr;
  logic              take;
  logic              do_push;
  logic              do_pop;
  logic              do_store;
  logic              do_load;
  logic [15:0]       next_data;

  assign sp_out = sp;

  // Decode the single effective operation, then pick the write-back value.
  // Push outranks pop, which outranks store, which outranks load.
  always_comb begin
    take      = in_valid & ~stall & ~flush;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_store  = 1'b0;
    do_load   = 1'b0;
    sp_inc    = sp + 1'b1;
    addr      = alu_result[ADDR_W-1:0];
    next_data = alu_result;
    if (take) begin
      if (push)           do_push  = 1'b1;
      else if (pop)       do_pop   = 1'b1;
      else if (mem_write) do_store = 1'b1;
      else if (mem_read)  do_load  = 1'b1;
    end
    // Reads are combinational. A write issued at the previous edge is
    // therefore already visible here, so no bypass path is required.
    if (do_pop)       next_data = mem[sp_inc];
    else if (do_load) next_data = mem[addr];
  end

  // MEM/WB register and stack pointer. Stall holds both; otherwise each
  // edge either loads a live bundle or drops in a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rdst      <= '0;
      wb_data      <= '0;
      sp           <= ADDR_W'(SP_RESET);
    end else if (!stall) begin
      if (take) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= reg_write;
        wb_rdst      <= rdst;
        wb_data      <= next_data;
      end else begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end
      if (do_push)     sp <= sp - 1'b1;
      else if (do_pop) sp <= sp_inc;
    end
  end

  // Data memory write port. Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push)       mem[sp]   <= store_data;
    else if (do_store) mem[addr] <= store_data;
  end

endmodule
